// File: rtl/pixel_draw_engine.sv
// pixel_draw_engine: turns PLOT / HLINE / CLEAR commands into a
// one-pixel-per-cycle write stream for a linear 1-bit framebuffer.
module pixel_draw_engine #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [9:0]        cmd_x0_i,
   input  logic [9:0]        cmd_x1_i,
   input  logic [8:0]        cmd_y_i,
   input  logic              cmd_color_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] pix_addr_o,
   output logic              pix_din_o,
   output logic              pix_wen_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLOT,
      S_LINE,
      S_CLEAR,
      S_FIN
   } state_t;

   localparam logic [9:0]        X_LAST = 10'(H_RES - 1);
   localparam logic [8:0]        Y_LAST = 9'(V_RES - 1);
   localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(H_RES * V_RES - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic              din_q, din_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              wen_q, wen_d;

   logic [9:0]        x1_clamp;
   logic [ADDR_W-1:0] row_base;
   logic [ADDR_W-1:0] addr_nx;
   logic              bad_xy;
   logic              accept;

   // Row base is y*640 built from two shifts so no multiplier is needed;
   // the span end is clamped to the last column rather than rejected.
   assign x1_clamp = (cmd_x1_i > X_LAST) ? X_LAST : cmd_x1_i;
   assign row_base = (ADDR_W'(cmd_y_i) << 9) + (ADDR_W'(cmd_y_i) << 7);
   assign addr_nx  = addr_q + ADDR_W'(1);
   assign bad_xy   = (cmd_x0_i > X_LAST) || (cmd_y_i > Y_LAST);
   assign accept   = cmd_valid_i && ready_q;

   // Next-state and registered-output decode.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      end_d   = end_q;
      din_d   = din_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      wen_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (accept) begin
               ready_d = 1'b0;
               busy_d  = 1'b1;
               din_d   = cmd_color_i;
               unique case (cmd_op_i)
                  2'b00: begin
                     state_d = S_FIN;
                     done_d  = 1'b1;
                  end
                  2'b01: begin
                     if (bad_xy) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                     end else begin
                        state_d = S_PLOT;
                        addr_d  = row_base + ADDR_W'(cmd_x0_i);
                        wen_d   = 1'b1;
                        done_d  = 1'b1;
                     end
                  end
                  2'b10: begin
                     if (bad_xy || (cmd_x0_i > cmd_x1_i)) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                     end else begin
                        state_d = S_LINE;
                        addr_d  = row_base + ADDR_W'(cmd_x0_i);
                        end_d   = row_base + ADDR_W'(x1_clamp);
                        wen_d   = 1'b1;
                        done_d  = (cmd_x0_i == x1_clamp);
                     end
                  end
                  2'b11: begin
                     state_d = S_CLEAR;
                     addr_d  = '0;
                     end_d   = A_LAST;
                     wen_d   = 1'b1;
                  end
               endcase
            end
         end
         S_PLOT, S_FIN: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
         S_LINE, S_CLEAR: begin
            // The span stops exactly at its end address: no carry into y.
            if (addr_q == end_q) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end else begin
               addr_d = addr_nx;
               wen_d  = 1'b1;
               done_d = (addr_nx == end_q);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         end_q   <= '0;
         din_q   <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         wen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         end_q   <= end_d;
         din_q   <= din_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         wen_q   <= wen_d;
      end
   end

   assign cmd_ready_o = ready_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign pix_addr_o  = addr_q;
   assign pix_din_o   = din_q;
   assign pix_wen_o   = wen_q;

endmodule
